// File: rtl/lsu.sv
// Load/store unit: issues one access at a time on a req/gnt/rvalid data bus,
// replicates store data across lanes and returns extended load data.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        ex_mtype_i,
  input  logic        ex_mem_rw_i,
  input  logic [1:0]  ex_mem_width_i,
  input  logic        ex_mem_rdtype_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, rdtype_q, done_q, misalign_q;
  logic [1:0]  width_q, off_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d, addr_q, rdata_q, rdata_d, shifted;
  logic        req_ok, aligned, accept, misalign_d, resp_fire;

  always_comb begin
    unique case (ex_mem_width_i)
      2'd2:    aligned = ~ex_addr_i[0];
      2'd3:    aligned = (ex_addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign req_ok     = ex_valid_i & ex_mtype_i & (state_q == IDLE) & (ex_mem_width_i != 2'd0);
  assign accept     = req_ok & aligned;
  assign misalign_d = req_ok & ~aligned;
  assign resp_fire  = (state_q == RESP) & bus_rvalid_i;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex_wdata_i;
    unique case (ex_mem_width_i)
      2'd1: begin
        be_d    = 4'b0001 << ex_addr_i[1:0];
        wdata_d = {4{ex_wdata_i[7:0]}};
      end
      2'd2: begin
        be_d    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (bus_gnt_i) state_d = RESP;
      RESP:    if (bus_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Halves are always 2-aligned, so shifting by the full byte offset also
  // selects the correct half lane.
  assign shifted = bus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    rdata_d = '0;
    if (resp_fire && !we_q) begin
      unique case (width_q)
        2'd1:    rdata_d = rdtype_q ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
        2'd2:    rdata_d = rdtype_q ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
        default: rdata_d = bus_rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      rdtype_q   <= 1'b0;
      width_q    <= '0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= resp_fire;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
      if (accept) begin
        we_q     <= ~ex_mem_rw_i;
        rdtype_q <= ex_mem_rdtype_i;
        width_q  <= ex_mem_width_i;
        off_q    <= ex_addr_i[1:0];
        be_q     <= be_d;
        wdata_q  <= wdata_d;
        addr_q   <= {ex_addr_i[31:2], 2'b00};
      end
    end
  end

  assign lsu_busy_o     = (state_q != IDLE) | accept;
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign bus_req_o      = (state_q == REQ);
  assign bus_we_o       = we_q;
  assign bus_addr_o     = addr_q;
  assign bus_be_o       = be_q;
  assign bus_wdata_o    = wdata_q;
endmodule
